lich_the_ky: RTL and testbench

LICH_THE_KY -- requirements
Module: lich_the_ky

---
 rtl/lich_pkg.sv | 31 +++
 rtl/bcd_updown.sv | 29 ++
 rtl/lich_the_ky.sv | 112 +++++++++++
 tb/tb_lich_the_ky.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lich_pkg.sv
// Shared constants and calendar helpers for the BCD date counter.
// Mode codes, BCD literals, divisibility-by-4 on BCD digits, and days-in-month.
package lich_pkg;

    localparam logic [2:0] MODE_SET_DAY   = 3'd3;
    localparam logic [2:0] MODE_SET_MONTH = 3'd4;
    localparam logic [2:0] MODE_SET_YEAR  = 3'd5;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_23 = 8'h23;
    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_01 = 8'h01;

    // A two-digit BCD value is a multiple of 4 when (even tens, units 0/4/8) or (odd tens, units 2/6).
    function automatic logic div4_bcd(input logic [7:0] v);
        logic [3:0] u;
        u = v[3:0];
        if (!v[4])
            return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
        return (u == 4'd2) || (u == 4'd6);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic leap);
        case (m)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/bcd_updown.sv
// Multi-digit BCD +1 / -1, wrapping 9..9 <-> 0..0; used for day, month and year.
module bcd_updown #(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] val,
    input  logic                up,
    output logic [4*DIGITS-1:0] res
);

    always_comb begin
        logic       carry;
        logic [3:0] d;
        res   = val;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = val[4*i +: 4];
            if (carry) begin
                if (up) begin
                    carry = (d == 4'd9);
                    res[4*i +: 4] = carry ? 4'd0 : d + 4'd1;
                end else begin
                    carry = (d == 4'd0);
                    res[4*i +: 4] = carry ? 4'd9 : d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/lich_the_ky.sv
// BCD calendar: advances the date at 23:59:59 in run mode, and lets the user
// step day/month/year in set modes with wrap and end-of-month clamping.
module lich_the_ky
    import lich_pkg::*;
#(
    parameter int          YEAR_DIGITS = 4,
    parameter logic [15:0] YEAR_MIN    = 16'h2000,
    parameter logic [15:0] YEAR_MAX    = 16'h2099,
    parameter logic [15:0] RST_DATE    = {8'h01, 8'h01},
    localparam int         YW          = 4 * YEAR_DIGITS
) (
    input  logic          clk_1Hz,
    input  logic          rst_n,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic [2:0]    mode,
    input  logic [7:0]    giay,
    input  logic [7:0]    phut,
    input  logic [7:0]    gio,
    output logic [7:0]    ngay,
    output logic [7:0]    thang,
    output logic [YW-1:0] nam,
    output logic          nhuan,
    output logic          sang_nam
);

    localparam logic [YW-1:0] Y_MIN = YEAR_MIN[YW-1:0];
    localparam logic [YW-1:0] Y_MAX = YEAR_MAX[YW-1:0];

    // Four-digit: a "00" low pair means a century year, leap only if the century pair is a multiple of 4.
    function automatic logic is_leap(input logic [YW-1:0] y);
        logic [15:0] y16;
        y16 = 16'(y);
        if (YEAR_DIGITS == 2)
            return div4_bcd(y16[7:0]);
        if (y16[7:0] == 8'h00)
            return div4_bcd(y16[15:8]);
        return div4_bcd(y16[7:0]);
    endfunction

    logic          set_mode, press, step_up, tick;
    logic [7:0]    ngay_step, thang_step;
    logic [YW-1:0] nam_step;
    logic [7:0]    ngay_n, thang_n, dim_cur, dim_new;
    logic [YW-1:0] nam_n;
    logic          sang_nam_n;

    assign set_mode = (mode == MODE_SET_DAY) || (mode == MODE_SET_MONTH) || (mode == MODE_SET_YEAR);
    assign press    = !btn_up || !btn_down;
    assign step_up  = !set_mode || !btn_up;
    assign tick     = !set_mode && (giay == BCD_59) && (phut == BCD_59) && (gio == BCD_23);
    assign nhuan    = is_leap(nam);

    bcd_updown #(.DIGITS(2))           u_day   (.val(ngay),  .up(step_up), .res(ngay_step));
    bcd_updown #(.DIGITS(2))           u_month (.val(thang), .up(step_up), .res(thang_step));
    bcd_updown #(.DIGITS(YEAR_DIGITS)) u_year  (.val(nam),   .up(step_up), .res(nam_step));

    always_comb begin
        ngay_n     = ngay;
        thang_n    = thang;
        nam_n      = nam;
        sang_nam_n = 1'b0;
        dim_cur    = days_in_month(thang, nhuan);
        dim_new    = dim_cur;
        if (tick) begin
            if (ngay < dim_cur) begin
                ngay_n = ngay_step;
            end else begin
                ngay_n = BCD_01;
                if (thang < BCD_12) begin
                    thang_n = thang_step;
                end else begin
                    thang_n    = BCD_01;
                    nam_n      = (nam == Y_MAX) ? Y_MIN : nam_step;
                    sang_nam_n = 1'b1;
                end
            end
        end else if (set_mode && press) begin
            unique case (mode)
                MODE_SET_DAY:
                    if (step_up) ngay_n = (ngay >= dim_cur) ? BCD_01 : ngay_step;
                    else         ngay_n = (ngay <= BCD_01) ? dim_cur : ngay_step;
                MODE_SET_MONTH:
                    if (step_up) thang_n = (thang >= BCD_12) ? BCD_01 : thang_step;
                    else         thang_n = (thang <= BCD_01) ? BCD_12 : thang_step;
                MODE_SET_YEAR:
                    if (step_up) nam_n = (nam >= Y_MAX) ? Y_MIN : nam_step;
                    else         nam_n = (nam <= Y_MIN) ? Y_MAX : nam_step;
                default: ;
            endcase
            // A month or year change may shorten the month under the current day.
            dim_new = days_in_month(thang_n, is_leap(nam_n));
            if (ngay_n > dim_new)
                ngay_n = dim_new;
        end
    end

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            ngay     <= RST_DATE[15:8];
            thang    <= RST_DATE[7:0];
            nam      <= Y_MIN;
            sang_nam <= 1'b0;
        end else begin
            ngay     <= ngay_n;
            thang    <= thang_n;
            nam      <= nam_n;
            sang_nam <= sang_nam_n;
        end
    end

endmodule

// File: tb/tb_lich_the_ky.sv
// Scoreboard bench for lich_the_ky: a decimal calendar model predicts each edge,
// a monitor compares the DUT every cycle; extra instances sweep the leap rules.
module tb_lich_the_ky;

    typedef struct packed {
        logic [7:0]  d;
        logic [7:0]  m;
        logic [15:0] y;
        logic        sn;
    } exp_t;

    logic        clk_1Hz = 1'b0;
    logic        rst_n   = 1'b1;
    logic        btn_up, btn_down;
    logic [2:0]  mode;
    logic [7:0]  giay, phut, gio;
    logic [7:0]  ngay, thang;
    logic [15:0] nam;
    logic        nhuan, sang_nam;

    logic [2:0]  mode_s;
    logic        btn_up_s;
    logic [7:0]  ngay_c, thang_c, ngay_d, thang_d;
    logic [15:0] nam_c;
    logic [7:0]  nam_d;
    logic        nhuan_c, sang_nam_c, nhuan_d, sang_nam_d;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t exp_q[$];
    int md_d, md_m, md_y, md_sn;

    always #5 clk_1Hz = ~clk_1Hz;

    lich_the_ky dut (
        .clk_1Hz(clk_1Hz), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .mode(mode),
        .giay(giay), .phut(phut), .gio(gio), .ngay(ngay), .thang(thang), .nam(nam),
        .nhuan(nhuan), .sang_nam(sang_nam)
    );

    lich_the_ky #(.YEAR_MIN(16'h1900), .YEAR_MAX(16'h2199)) dut_c (
        .clk_1Hz(clk_1Hz), .rst_n(rst_n), .btn_up(btn_up_s), .btn_down(1'b1), .mode(mode_s),
        .giay(8'h00), .phut(8'h00), .gio(8'h00), .ngay(ngay_c), .thang(thang_c), .nam(nam_c),
        .nhuan(nhuan_c), .sang_nam(sang_nam_c)
    );

    lich_the_ky #(.YEAR_DIGITS(2), .YEAR_MIN(16'h0000), .YEAR_MAX(16'h0099)) dut_d (
        .clk_1Hz(clk_1Hz), .rst_n(rst_n), .btn_up(btn_up_s), .btn_down(1'b1), .mode(mode_s),
        .giay(8'h00), .phut(8'h00), .gio(8'h00), .ngay(ngay_d), .thang(thang_d), .nam(nam_d),
        .nhuan(nhuan_d), .sang_nam(sang_nam_d)
    );

    function automatic logic [7:0] bcd8(input int v);
        return 8'(((v / 10) % 10) * 16 + v % 10);
    endfunction

    function automatic logic [15:0] bcd16(input int v);
        return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    function automatic bit leap4(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int dim(input int m, input int y);
        if (m == 2) return leap4(y) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        md_d = 1; md_m = 1; md_y = 2000; md_sn = 0;
    endtask

    task automatic model_apply(input int md, input bit up, input bit dn, input int g, input int p, input int h);
        bit set;
        int dir;
        set   = (md == 3) || (md == 4) || (md == 5);
        md_sn = 0;
        if (!set && g == 59 && p == 59 && h == 23) begin
            if (md_d < dim(md_m, md_y)) md_d++;
            else begin
                md_d = 1;
                if (md_m < 12) md_m++;
                else begin
                    md_m  = 1;
                    md_y  = (md_y == 2099) ? 2000 : md_y + 1;
                    md_sn = 1;
                end
            end
        end else if (set && (!up || !dn)) begin
            dir = !up ? 1 : -1;
            if (md == 3) begin
                md_d += dir;
                if (md_d > dim(md_m, md_y)) md_d = 1;
                if (md_d < 1) md_d = dim(md_m, md_y);
            end else if (md == 4) begin
                md_m += dir;
                if (md_m > 12) md_m = 1;
                if (md_m < 1) md_m = 12;
            end else begin
                md_y += dir;
                if (md_y > 2099) md_y = 2000;
                if (md_y < 2000) md_y = 2099;
            end
            if (md_d > dim(md_m, md_y)) md_d = dim(md_m, md_y);
        end
    endtask

    task automatic step(input int md, input bit up, input bit dn, input int g, input int p, input int h);
        exp_t e;
        @(negedge clk_1Hz);
        mode = 3'(md); btn_up = up; btn_down = dn;
        giay = bcd8(g); phut = bcd8(p); gio = bcd8(h);
        model_apply(md, up, dn, g, p, h);
        e.d = bcd8(md_d); e.m = bcd8(md_m); e.y = bcd16(md_y); e.sn = md_sn[0];
        exp_q.push_back(e);
        @(posedge clk_1Hz);
    endtask

    task automatic goto_date(input int td, input int tm, input int ty);
        for (int i = 0; i < 120 && md_y != ty; i++) step(5, 0, 1, 0, 0, 0);
        for (int i = 0; i < 14 && md_m != tm; i++) step(4, 0, 1, 0, 0, 0);
        for (int i = 0; i < 33 && md_d != td; i++) step(3, 0, 1, 0, 0, 0);
    endtask

    always @(posedge clk_1Hz) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("date", 64'({ngay, thang, nam, sang_nam}), 64'(e));
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int modes[8] = '{0, 3, 4, 5, 1, 7, 0, 3};
        int yc, yd;
        int md, g, p, h;
        btn_up = 1'b1; btn_down = 1'b1; mode = 3'd0;
        giay = 8'h00; phut = 8'h00; gio = 8'h00;
        mode_s = 3'd0; btn_up_s = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk_1Hz); @(posedge clk_1Hz); #1;
        check("reset_ngay", 64'(ngay), 64'h01);
        check("reset_thang", 64'(thang), 64'h01);
        check("reset_nam", 64'(nam), 64'h2000);
        check("reset_sang_nam", 64'(sang_nam), 64'h0);
        check("reset_nhuan", 64'(nhuan), 64'h1);
        @(negedge clk_1Hz);
        rst_n = 1'b1;
        model_reset();

        // Leap cascade through 29 February 2024.
        goto_date(28, 2, 2024);
        step(0, 1, 1, 59, 59, 23); #2;
        check("leap_29", 64'({ngay, thang}), 64'h2902);
        step(0, 1, 1, 59, 59, 23); #2;
        check("leap_to_march", 64'({ngay, thang, nam}), 64'h0103_2024);

        // Year wrap 2099 -> 2000 with a one-cycle rollover pulse.
        goto_date(31, 12, 2099);
        step(0, 1, 1, 59, 59, 23); #2;
        check("wrap_date", 64'({ngay, thang, nam}), 64'h0101_2000);
        check("wrap_pulse", 64'(sang_nam), 64'h1);
        step(0, 1, 1, 0, 0, 0); #2;
        check("wrap_pulse_end", 64'(sang_nam), 64'h0);

        // Clamping on month and year changes.
        goto_date(31, 1, 2023);
        step(4, 0, 1, 0, 0, 0); #2;
        check("clamp_month", 64'({ngay, thang}), 64'h2802);
        goto_date(29, 2, 2024);
        step(5, 0, 1, 0, 0, 0); #2;
        check("clamp_year", 64'({ngay, nam}), 64'h28_2025);

        // Set wrap, button priority, and suppressed rollover in set mode.
        goto_date(1, 4, 2025);
        step(3, 1, 0, 0, 0, 0); #2;
        check("day_wrap_down", 64'(ngay), 64'h30);
        step(3, 0, 1, 0, 0, 0); #2;
        check("day_wrap_up", 64'(ngay), 64'h01);
        step(3, 0, 0, 0, 0, 0); #2;
        check("both_buttons", 64'(ngay), 64'h02);
        step(5, 1, 1, 59, 59, 23); #2;
        check("set_no_roll", 64'({ngay, thang, sang_nam}), 64'({8'h02, 8'h04, 1'b0}));

        // Asynchronous reset between edges while setting.
        step(3, 0, 1, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst", 64'({ngay, thang, nam, sang_nam}), 64'({8'h01, 8'h01, 16'h2000, 1'b0}));
        rst_n = 1'b1;
        model_reset();
        step(0, 1, 1, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            md = modes[$urandom_range(0, 7)];
            if ($urandom_range(0, 2) == 0) begin
                g = 59; p = 59; h = 23;
            end else begin
                g = $urandom_range(0, 59); p = $urandom_range(0, 59); h = $urandom_range(0, 23);
            end
            step(md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g, p, h);
        end

        @(negedge clk_1Hz);
        mode = 3'd0; btn_up = 1'b1; btn_down = 1'b1; giay = 8'h00;
        @(posedge clk_1Hz); #2;
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        // Leap-rule sweeps across centuries and in two-digit mode.
        yc = 1900; yd = 0;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk_1Hz);
            check("sweep_nam_c", 64'(nam_c), 64'(bcd16(yc)));
            check("sweep_nhuan_c", 64'(nhuan_c), 64'(leap4(yc)));
            check("sweep_nam_d", 64'(nam_d), 64'(bcd8(yd)));
            check("sweep_nhuan_d", 64'(nhuan_d), 64'(yd % 4 == 0));
            mode_s = 3'd5; btn_up_s = 1'b0;
            @(posedge clk_1Hz);
            yc = (yc == 2199) ? 1900 : yc + 1;
            yd = (yd + 1) % 100;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
